// File: rtl/cycle_stats_if.sv
// ============================================================================
// cycle_stats_if : sample, clear, snapshot and statistics bundle for cycle_stats
// Revision 1.0
// ============================================================================
`default_nettype none

interface cycle_stats_if;
   logic        enable;
   logic        sample_valid;
   logic [31:0] sample_value;
   logic        clear;
   logic        snap_req;
   logic        snap_ready;
   logic [31:0] sample_cnt;
   logic [31:0] last_value;
   logic        stats_empty;
   logic        snap_valid;
   logic [31:0] snap_cnt;
   logic [31:0] snap_min;
   logic [31:0] snap_max;
   logic [47:0] snap_sum;
   logic        sum_sat;
   logic        snap_miss;

   modport master (
      output enable, sample_valid, sample_value, clear, snap_req, snap_ready,
      input  sample_cnt, last_value, stats_empty, snap_valid, snap_cnt,
             snap_min, snap_max, snap_sum, sum_sat, snap_miss
   );

   modport slave (
      input  enable, sample_valid, sample_value, clear, snap_req, snap_ready,
      output sample_cnt, last_value, stats_empty, snap_valid, snap_cnt,
             snap_min, snap_max, snap_sum, sum_sat, snap_miss
   );
endinterface

`default_nettype wire

// File: rtl/cycle_stats.sv
// ============================================================================
// cycle_stats : live count/min/max/sum of cycle measurements with snapshot
// Revision 1.0
// ============================================================================
`default_nettype none

module cycle_stats (
   input  wire logic     clk,
   input  wire logic     resetn,
   cycle_stats_if.slave  bus
);

   typedef enum logic [0:0] {
      EMPTY  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] cnt_r;
   logic [31:0] last_r;
   logic [31:0] min_r;
   logic [31:0] max_r;
   logic [47:0] sum_r;
   logic        sat_r;
   logic        miss_r;

   logic        snap_valid_r;
   logic [31:0] snap_cnt_r;
   logic [31:0] snap_min_r;
   logic [31:0] snap_max_r;
   logic [47:0] snap_sum_r;

   logic        accept;
   logic        capture;
   logic        drop;
   logic        handoff;
   logic [48:0] sum_add;
   logic [47:0] sum_next;
   logic [31:0] cnt_next;
   logic [31:0] min_next;
   logic [31:0] max_next;

   always_comb begin
      accept   = bus.sample_valid & bus.enable & ~bus.clear;
      capture  = bus.snap_req & ~snap_valid_r;
      drop     = bus.snap_req & snap_valid_r;
      handoff  = snap_valid_r & bus.snap_ready;
      sum_add  = {1'b0, sum_r} + {17'd0, bus.sample_value};
      sum_next = sum_add[48] ? {48{1'b1}} : sum_add[47:0];
      cnt_next = (cnt_r == 32'hFFFF_FFFF) ? cnt_r : cnt_r + 32'd1;
      // The first sample after reset/clear seeds both extremes.
      if (state == EMPTY) begin
         min_next = bus.sample_value;
         max_next = bus.sample_value;
      end else begin
         min_next = (bus.sample_value < min_r) ? bus.sample_value : min_r;
         max_next = (bus.sample_value > max_r) ? bus.sample_value : max_r;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (accept)    state_next = ACTIVE;
         ACTIVE:  if (bus.clear) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r  <= 32'd0;
         last_r <= 32'd0;
         min_r  <= 32'hFFFF_FFFF;
         max_r  <= 32'd0;
         sum_r  <= 48'd0;
         sat_r  <= 1'b0;
         miss_r <= 1'b0;
      end else if (bus.clear) begin
         cnt_r  <= 32'd0;
         last_r <= 32'd0;
         min_r  <= 32'hFFFF_FFFF;
         max_r  <= 32'd0;
         sum_r  <= 48'd0;
         sat_r  <= 1'b0;
         miss_r <= 1'b0;
      end else begin
         if (accept) begin
            cnt_r  <= cnt_next;
            last_r <= bus.sample_value;
            min_r  <= min_next;
            max_r  <= max_next;
            sum_r  <= sum_next;
            if (sum_add[48]) sat_r <= 1'b1;
         end
         if (drop) miss_r <= 1'b1;
      end
   end

   // Capture uses pre-edge live values, so a same-edge sample or clear is
   // never reflected in the snapshot being taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         snap_valid_r <= 1'b0;
         snap_cnt_r   <= 32'd0;
         snap_min_r   <= 32'd0;
         snap_max_r   <= 32'd0;
         snap_sum_r   <= 48'd0;
      end else if (capture) begin
         snap_valid_r <= 1'b1;
         snap_cnt_r   <= cnt_r;
         snap_sum_r   <= sum_r;
         snap_min_r   <= (state == EMPTY) ? 32'd0 : min_r;
         snap_max_r   <= (state == EMPTY) ? 32'd0 : max_r;
      end else if (handoff) begin
         snap_valid_r <= 1'b0;
      end
   end

   assign bus.sample_cnt  = cnt_r;
   assign bus.last_value  = last_r;
   assign bus.stats_empty = (state == EMPTY);
   assign bus.snap_valid  = snap_valid_r;
   assign bus.snap_cnt    = snap_cnt_r;
   assign bus.snap_min    = snap_min_r;
   assign bus.snap_max    = snap_max_r;
   assign bus.snap_sum    = snap_sum_r;
   assign bus.sum_sat     = sat_r;
   assign bus.snap_miss   = miss_r;

endmodule

`default_nettype wire

// File: tb/tb_cycle_stats.sv
// ============================================================================
// tb_cycle_stats : directed self-checking bench for cycle_stats
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cycle_stats;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   cycle_stats_if bus ();

   cycle_stats dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic put_sample(input logic [31:0] v);
      bus.sample_valid = 1'b1;
      bus.sample_value = v;
      tick();
      bus.sample_valid = 1'b0;
   endtask

   task automatic snap_pulse;
      bus.snap_req = 1'b1;
      tick();
      bus.snap_req = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cnt"},   bus.sample_cnt,  64'd0);
      chk({tag, "_last"},  bus.last_value,  64'd0);
      chk({tag, "_empty"}, bus.stats_empty, 64'd1);
      chk({tag, "_sv"},    bus.snap_valid,  64'd0);
      chk({tag, "_scnt"},  bus.snap_cnt,    64'd0);
      chk({tag, "_smin"},  bus.snap_min,    64'd0);
      chk({tag, "_smax"},  bus.snap_max,    64'd0);
      chk({tag, "_ssum"},  bus.snap_sum,    64'd0);
      chk({tag, "_sat"},   bus.sum_sat,     64'd0);
      chk({tag, "_miss"},  bus.snap_miss,   64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_value = 32'd0;
      bus.clear        = 1'b0;
      bus.snap_req     = 1'b0;
      bus.snap_ready   = 1'b0;
      resetn           = 1'b1;
      #1 resetn = 1'b0;
      #2;
      chk_reset("por");
      @(negedge clk);
      resetn = 1'b1;

      // Basic accumulation and a one-cycle snapshot
      bus.enable     = 1'b1;
      bus.snap_ready = 1'b1;
      put_sample(32'd10);
      chk("s1_cnt",   bus.sample_cnt,  64'd1);
      chk("s1_last",  bus.last_value,  64'd10);
      chk("s1_empty", bus.stats_empty, 64'd0);
      put_sample(32'd4);
      put_sample(32'd25);
      chk("s3_cnt",  bus.sample_cnt, 64'd3);
      chk("s3_last", bus.last_value, 64'd25);
      snap_pulse();
      chk("a_sv",   bus.snap_valid, 64'd1);
      chk("a_scnt", bus.snap_cnt,   64'd3);
      chk("a_smin", bus.snap_min,   64'd4);
      chk("a_smax", bus.snap_max,   64'd25);
      chk("a_ssum", bus.snap_sum,   64'd39);
      tick();
      chk("a_sv_drop", bus.snap_valid, 64'd0);

      // Snapshot held off by snap_ready=0 for five cycles
      bus.snap_ready = 1'b0;
      snap_pulse();
      chk("b_sv", bus.snap_valid, 64'd1);
      tick();
      snap_pulse();
      chk("b_miss", bus.snap_miss, 64'd1);
      put_sample(32'd7);
      put_sample(32'd100);
      bus.enable = 1'b0;
      put_sample(32'd999);
      bus.enable = 1'b1;
      chk("b_cnt",  bus.sample_cnt, 64'd5);
      chk("b_last", bus.last_value, 64'd100);
      chk("b_sv5",  bus.snap_valid, 64'd1);
      chk("b_scnt", bus.snap_cnt,   64'd3);
      chk("b_smax", bus.snap_max,   64'd25);
      chk("b_ssum", bus.snap_sum,   64'd39);
      bus.snap_ready = 1'b1;
      tick();
      chk("b_sv_drop", bus.snap_valid, 64'd0);

      // Sample on the capture edge is excluded, then included next time
      bus.sample_valid = 1'b1;
      bus.sample_value = 32'd1;
      bus.snap_req     = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      bus.snap_req     = 1'b0;
      chk("c_scnt", bus.snap_cnt,   64'd5);
      chk("c_smin", bus.snap_min,   64'd4);
      chk("c_smax", bus.snap_max,   64'd100);
      chk("c_ssum", bus.snap_sum,   64'd146);
      chk("c_cnt",  bus.sample_cnt, 64'd6);
      tick();
      snap_pulse();
      chk("c2_scnt", bus.snap_cnt, 64'd6);
      chk("c2_smin", bus.snap_min, 64'd1);
      chk("c2_ssum", bus.snap_sum, 64'd147);
      tick();

      // clear together with snap_req; later clear leaves snapshot alone
      bus.snap_ready = 1'b0;
      bus.clear      = 1'b1;
      snap_pulse();
      bus.clear = 1'b0;
      chk("d_scnt",  bus.snap_cnt,    64'd6);
      chk("d_ssum",  bus.snap_sum,    64'd147);
      chk("d_empty", bus.stats_empty, 64'd1);
      chk("d_cnt",   bus.sample_cnt,  64'd0);
      chk("d_last",  bus.last_value,  64'd0);
      chk("d_miss",  bus.snap_miss,   64'd0);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("d_sv_keep",   bus.snap_valid, 64'd1);
      chk("d_scnt_keep", bus.snap_cnt,   64'd6);
      // snap_req on the acceptance edge is dropped
      bus.snap_ready = 1'b1;
      snap_pulse();
      chk("d_acc_sv",   bus.snap_valid, 64'd0);
      chk("d_acc_miss", bus.snap_miss,  64'd1);

      // Sample coinciding with clear is discarded; empty snapshot is zero
      put_sample(32'd50);
      chk("e_cnt1", bus.sample_cnt, 64'd1);
      bus.clear = 1'b1;
      put_sample(32'd60);
      bus.clear = 1'b0;
      chk("e_cnt0",  bus.sample_cnt,  64'd0);
      chk("e_empty", bus.stats_empty, 64'd1);
      snap_pulse();
      chk("e_sv",   bus.snap_valid, 64'd1);
      chk("e_scnt", bus.snap_cnt,   64'd0);
      chk("e_smin", bus.snap_min,   64'd0);
      chk("e_smax", bus.snap_max,   64'd0);
      chk("e_ssum", bus.snap_sum,   64'd0);
      tick();

      // Sum saturation boundary
      bus.sample_valid = 1'b1;
      bus.sample_value = 32'hFFFF_FFFF;
      repeat (65536) tick();
      bus.sample_valid = 1'b0;
      snap_pulse();
      chk("f_ssum", bus.snap_sum,   64'h0000_FFFF_FFFF_0000);
      chk("f_sat0", bus.sum_sat,    64'd0);
      chk("f_scnt", bus.snap_cnt,   64'd65536);
      tick();
      put_sample(32'hFFFF_FFFF);
      chk("f_sat1", bus.sum_sat,    64'd1);
      chk("f_cnt",  bus.sample_cnt, 64'd65537);
      snap_pulse();
      chk("f_ssum_pin", bus.snap_sum, 64'h0000_FFFF_FFFF_FFFF);
      chk("f_smin",     bus.snap_min, 64'h0000_0000_FFFF_FFFF);
      chk("f_smax",     bus.snap_max, 64'h0000_0000_FFFF_FFFF);
      tick();

      // Asynchronous reset while a snapshot is pending
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      for (int i = 1; i <= 7; i++) put_sample(32'(i));
      bus.snap_ready = 1'b0;
      snap_pulse();
      chk("g_sv",   bus.snap_valid, 64'd1);
      chk("g_scnt", bus.snap_cnt,   64'd7);
      #3 resetn = 1'b0;
      #1;
      chk_reset("arst");
      @(negedge clk);
      resetn = 1'b1;
      put_sample(32'd9);
      chk("h_cnt",  bus.sample_cnt, 64'd1);
      chk("h_last", bus.last_value, 64'd9);
      bus.snap_ready = 1'b1;
      snap_pulse();
      chk("h_smin", bus.snap_min, 64'd9);
      chk("h_smax", bus.snap_max, 64'd9);
      chk("h_ssum", bus.snap_sum, 64'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cycle_stats.md
CYCLE_STATS -- requirements
Module: cycle_stats

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, asynchronous and active-low; one clock, no other clock domains.
REQ-003 enable  in  1  high: samples accepted; low: samples ignored.
REQ-004 sample_valid  in  1  single-cycle pulse; a measurement is present on sample_value (driven from the cycle counter's count_valid).
REQ-005 sample_value  in  32  elapsed-cycle measurement, unsigned.
REQ-006 clear  in  1  single-cycle pulse; return all statistics to the empty state.
REQ-007 snap_req  in  1  single-cycle pulse; request a frozen copy of the statistics.
REQ-008 snap_ready  in  1  consumer accepts the snapshot when high with snap_valid.
REQ-009 sample_cnt  out  32  number of accepted samples, live.
REQ-010 last_value  out  32  most recently accepted sample, live.
REQ-011 stats_empty  out  1  high while no sample has been accepted since reset/clear.
REQ-012 snap_valid  out  1  snapshot outputs hold a valid copy.
REQ-013 snap_cnt / snap_min / snap_max  out  32 each  frozen count, minimum, maximum.
REQ-014 snap_sum  out  48  frozen sum of accepted samples.
REQ-015 sum_sat  out  1  sticky; the sum has saturated since reset/clear.
REQ-016 snap_miss  out  1  sticky; a snap_req was dropped since reset/clear.

Function
REQ-017 Sample accepted when sample_valid=1, enable=1 and clear=0 on the same edge; all other samples are discarded without effect.
REQ-018 Live statistics update on the accepting edge and are visible at the outputs from the following cycle (1-cycle latency, registered outputs).
REQ-019 The block SHALL implement two states, EMPTY and ACTIVE: EMPTY->ACTIVE on an accepted sample; ACTIVE->EMPTY on clear; no other transitions. stats_empty=1 exactly in EMPTY.
REQ-020 On accept: last_value<=sample_value; min/max are updated by unsigned compare; in EMPTY, min and max both load sample_value.
REQ-021 sample_cnt saturates at 0xFFFF_FFFF; once saturated, further samples still update min, max, last_value and the sum.
REQ-022 The sum is 48-bit unsigned; if an addition would exceed 0xFFFF_FFFF_FFFF, the sum holds all-ones and sum_sat sets.
REQ-023 Snapshot capture occurs on an edge where snap_req=1 and snap_valid=0. The snap_* registers load the live values as they were before that edge, and snap_valid goes high from the next cycle.
REQ-024 A sample accepted on the same edge as a capture is excluded from that snapshot but included in the live statistics.
REQ-025 A snapshot taken in EMPTY reports snap_cnt=0, snap_min=0, snap_max=0 and snap_sum=0.
REQ-026 snap_valid and the snap_* outputs are held stable until an edge with snap_valid=1 and snap_ready=1; snap_valid then clears on that edge.
REQ-027 snap_req while snap_valid=1 (including the acceptance edge itself) is dropped and sets snap_miss; no capture occurs.
REQ-028 clear on the same edge as snap_req: the capture takes the pre-clear values, and the live statistics are then emptied.
REQ-029 clear resets the live statistics, sum_sat and snap_miss. It does not affect a pending snapshot (snap_valid and the snap_* outputs are unchanged).
REQ-030 enable low does not block snapshot or clear operations.

Reset
REQ-031 resetn low asynchronously forces: state EMPTY; sample_cnt=0; last_value=0; stats_empty=1; snap_valid=0; all snap_* outputs=0; sum_sat=0; snap_miss=0. The internal min register is set to 0xFFFF_FFFF and the internal max register to 0.
REQ-032 Reset asserted mid-operation (including while snap_valid=1) discards all state. After release, the first edge behaves as from power-up.

Verification
REQ-033 Samples 10, 4, 25 with enable=1, then snap_req, snap_ready=1 -> snap_cnt=3, snap_min=4, snap_max=25, snap_sum=39; snap_valid high exactly one cycle.
REQ-034 snap_req held off by snap_ready=0 for 5 cycles, with a second snap_req and 2 samples meanwhile -> snapshot outputs unchanged throughout; snap_miss=1; live sample_cnt +2.
REQ-035 sample_valid and clear on the same edge, then snap_req -> snap_cnt=0, snap_min=0, snap_max=0, stats_empty=1.
REQ-036 Sum forced near its limit (e.g. 65537 samples of 0xFFFF_FFFF) -> sum pinned at 0xFFFF_FFFF_FFFF; sum_sat=1; sample_cnt=65537.
REQ-037 Sample and snap_req on the same edge -> snapshot excludes the sample; the next snapshot includes it.
REQ-038 resetn pulsed low while snap_valid=1 and sample_cnt=7 -> all outputs at their reset values immediately, without waiting for a clock edge.
